pc_branch_unit: RTL and testbench

- Fetch-side control stage that consumes the ALU's condition outputs (ZERO, BEVEN, PARITY, EQUAL).
- Latches those flags into an architectural flag register and holds the program counter.
- Resolves conditional/unconditional branches against the registered flags.
- Runs the Start/Ack run-halt handshake with the testbench/host, and counts executed cycles for performance reporting.

---
 rtl/pc_branch_unit.sv | 114 +++++++++++
 tb/tb_pc_branch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Fetch-side control stage: architectural flag register, program counter,
// branch resolution, Start/Ack run-halt handshake and a saturating run-cycle counter.
module pc_branch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt_req,
    input  logic             Flag_we,
    input  logic             ZERO_in,
    input  logic             BEVEN_in,
    input  logic             PARITY_in,
    input  logic             EQUAL_in,
    input  logic             Branch_en,
    input  logic [2:0]       Branch_cond,
    input  logic [PC_W-1:0]  Branch_target,
    output logic [PC_W-1:0]  PC,
    output logic [3:0]       Flags,
    output logic             Running,
    output logic             Ack,
    output logic [CNT_W-1:0] Cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, ack_q;
    logic             branch_taken;

    // Flag register layout is {ZERO, BEVEN, PARITY, EQUAL}.
    always_comb begin
        branch_taken = 1'b0;
        case (Branch_cond)
            3'd0:    branch_taken = 1'b1;
            3'd1:    branch_taken = flags_q[3];
            3'd2:    branch_taken = !flags_q[3];
            3'd3:    branch_taken = flags_q[0];
            3'd4:    branch_taken = !flags_q[0];
            3'd5:    branch_taken = flags_q[2];
            3'd6:    branch_taken = flags_q[1];
            default: branch_taken = !flags_q[1];
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    flags_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt_req) begin
                        state_d = HALTED;
                    end else begin
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                        // Branches resolve on the old flags; no bypass of a same-cycle write.
                        if (Branch_en && branch_taken) pc_d = Branch_target;
                        else                           pc_d = pc_q + 1'b1;
                    end
                    if (Flag_we) flags_d = {ZERO_in, BEVEN_in, PARITY_in, EQUAL_in};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            flags_q   <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            ack_q     <= (state_d == HALTED);
        end
    end

    assign PC          = pc_q;
    assign Flags       = flags_q;
    assign Cycle_count = cnt_q;
    assign Running     = running_q;
    assign Ack         = ack_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; CNT_W is shrunk to 4 so counter saturation is reachable.
module tb_pc_branch_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset, Start, Stall, Halt_req, Flag_we;
    logic             ZERO_in, BEVEN_in, PARITY_in, EQUAL_in;
    logic             Branch_en;
    logic [2:0]       Branch_cond;
    logic [PC_W-1:0]  Branch_target;
    logic [PC_W-1:0]  PC;
    logic [3:0]       Flags;
    logic             Running, Ack;
    logic [CNT_W-1:0] Cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
        .Flag_we(Flag_we), .ZERO_in(ZERO_in), .BEVEN_in(BEVEN_in), .PARITY_in(PARITY_in),
        .EQUAL_in(EQUAL_in), .Branch_en(Branch_en), .Branch_cond(Branch_cond),
        .Branch_target(Branch_target), .PC(PC), .Flags(Flags), .Running(Running),
        .Ack(Ack), .Cycle_count(Cycle_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Reset = 0; Start = 0; Stall = 0; Halt_req = 0; Flag_we = 0;
        ZERO_in = 0; BEVEN_in = 0; PARITY_in = 0; EQUAL_in = 0;
        Branch_en = 0; Branch_cond = 3'd0; Branch_target = '0;
    endtask

    task automatic set_flags_in(input logic [3:0] f);
        {ZERO_in, BEVEN_in, PARITY_in, EQUAL_in} = f;
    endtask

    task automatic branch(input logic [2:0] cond, input logic [PC_W-1:0] tgt);
        Branch_en = 1; Branch_cond = cond; Branch_target = tgt;
    endtask

    task automatic check_state(input string tag, input logic [PC_W-1:0] pc, input logic [3:0] fl,
                               input logic [CNT_W-1:0] cnt, input logic run, input logic ack);
        check({tag, ".pc"},  32'(PC),          32'(pc));
        check({tag, ".fl"},  32'(Flags),       32'(fl));
        check({tag, ".cnt"}, 32'(Cycle_count), 32'(cnt));
        check({tag, ".run"}, 32'(Running),     32'(run));
        check({tag, ".ack"}, 32'(Ack),         32'(ack));
    endtask

    initial begin
        idle_inputs();
        Reset = 1;
        step();
        check_state("reset", 10'h000, 4'h0, 4'd0, 0, 0);

        // IDLE ignores everything but Start
        Reset = 0; branch(3'd0, 10'h155); Flag_we = 1; set_flags_in(4'hF);
        step();
        check_state("idle_hold", 10'h000, 4'h0, 4'd0, 0, 0);
        idle_inputs();

        Start = 1;
        step();
        check_state("start", 10'h000, 4'h0, 4'd0, 1, 0);
        Start = 0;

        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), 32'(PC), 32'(i));
        end
        check_state("seq5", 10'h005, 4'h0, 4'd5, 1, 0);

        // Stall masks halt, branch and flag write
        Stall = 1; Halt_req = 1; Flag_we = 1; set_flags_in(4'hF); branch(3'd0, 10'h300);
        for (int i = 0; i < 3; i++) step();
        check_state("stall", 10'h005, 4'h0, 4'd5, 1, 0);
        idle_inputs();

        Flag_we = 1; set_flags_in(4'b1000);
        step();
        check_state("fw_zero", 10'h006, 4'b1000, 4'd6, 1, 0);
        idle_inputs();

        branch(3'd1, 10'h040);
        step();
        check("br_zero", 32'(PC), 32'h040);
        branch(3'd2, 10'h100);
        step();
        check("br_nzero", 32'(PC), 32'h041);

        // Same-cycle write and branch: branch sees old EQUAL=0
        idle_inputs(); Flag_we = 1; set_flags_in(4'b0001); branch(3'd3, 10'h200);
        step();
        check_state("nobypass", 10'h042, 4'b0001, 4'd9, 1, 0);
        idle_inputs();

        branch(3'd3, 10'h0A0);
        step();
        check("br_eq", 32'(PC), 32'h0A0);
        branch(3'd0, 10'h3FE);
        step();
        check("br_always", 32'(PC), 32'h3FE);
        branch(3'd4, 10'h123);
        step();
        check("br_neq", 32'(PC), 32'h3FF);
        idle_inputs();
        step();
        check_state("wrap", 10'h000, 4'b0001, 4'd13, 1, 0);

        step(); step(); step();
        check_state("sat", 10'h003, 4'b0001, 4'd15, 1, 0);

        Flag_we = 1; set_flags_in(4'b0100);
        step();
        check("fw_beven", 32'(Flags), 32'b0100);
        idle_inputs();
        branch(3'd5, 10'h010);
        step();
        check("br_beven", 32'(PC), 32'h010);
        branch(3'd6, 10'h300);
        step();
        check("br_parity", 32'(PC), 32'h011);
        branch(3'd7, 10'h012);
        step();
        check("br_nparity", 32'(PC), 32'h012);

        // Halt: PC holds, flag write honoured, branch ignored
        idle_inputs(); Halt_req = 1; Flag_we = 1; set_flags_in(4'b0010); branch(3'd0, 10'h200);
        step();
        check_state("halt", 10'h012, 4'b0010, 4'd15, 0, 1);
        idle_inputs(); Flag_we = 1; set_flags_in(4'hF); branch(3'd0, 10'h200);
        step();
        check_state("halted_hold", 10'h012, 4'b0010, 4'd15, 0, 1);
        idle_inputs();

        Start = 1;
        step();
        check_state("restart", 10'h000, 4'h0, 4'd0, 1, 0);

        // Start stays high through RUN and must not restart the PC
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin Flag_we = 1; set_flags_in(4'hF); end
            step();
        end
        check_state("run_to_20", 10'h020, 4'hF, 4'd15, 1, 0);

        idle_inputs(); Reset = 1; Start = 1; Halt_req = 1;
        step();
        check_state("mid_reset", 10'h000, 4'h0, 4'd0, 0, 0);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
